// File: rtl/delay_line_scheduler.sv
// Two-channel delayed-pulse scheduler: compares FIFO head timestamps against a
// wrapping counter, drops stale heads and triggers a shared pulse generator.
module delay_line_scheduler #(
  parameter int unsigned CTR_WIDTH   = 17,
  parameter int unsigned LATE_WINDOW = 64,
  parameter int unsigned STAT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [CTR_WIDTH-1:0]  ctr,
  input  logic                  ch0_empty,
  input  logic [CTR_WIDTH-1:0]  ch0_data,
  input  logic                  ch1_empty,
  input  logic [CTR_WIDTH-1:0]  ch1_data,
  output logic                  ch0_rden,
  output logic                  ch1_rden,
  input  logic                  gen_busy,
  output logic                  gen_trigger,
  output logic                  gen_sel,
  output logic [STAT_WIDTH-1:0] drop_count,
  output logic [STAT_WIDTH-1:0] collision_count
);

  localparam int unsigned          MSB  = CTR_WIDTH - 1;
  localparam logic [CTR_WIDTH-1:0] LATE = CTR_WIDTH'(LATE_WINDOW);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t               state;
  logic                 rr_ptr;
  logic [CTR_WIDTH-1:0] age0_c, age1_c;
  logic                 due0_c, due1_c, stale0_c, stale1_c;
  logic                 both_due_c, tie_c, win_c;

  // Head classification; the age MSB marks a timestamp still in the future.
  always_comb begin
    age0_c     = ctr - ch0_data;
    age1_c     = ctr - ch1_data;
    due0_c     = !ch0_empty && !age0_c[MSB] && (age0_c < LATE);
    due1_c     = !ch1_empty && !age1_c[MSB] && (age1_c < LATE);
    stale0_c   = !ch0_empty && !age0_c[MSB] && !(age0_c < LATE);
    stale1_c   = !ch1_empty && !age1_c[MSB] && !(age1_c < LATE);
    both_due_c = due0_c && due1_c;
    tie_c      = both_due_c && (age0_c == age1_c);
    win_c      = due1_c;
    if (both_due_c) begin
      win_c = tie_c ? rr_ptr : (age1_c > age0_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rr_ptr          <= 1'b0;
      ch0_rden        <= 1'b0;
      ch1_rden        <= 1'b0;
      gen_trigger     <= 1'b0;
      gen_sel         <= 1'b0;
      drop_count      <= '0;
      collision_count <= '0;
    end else begin
      ch0_rden    <= 1'b0;
      ch1_rden    <= 1'b0;
      gen_trigger <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            if (stale0_c || stale1_c) begin
              ch0_rden <= stale0_c;
              ch1_rden <= !stale0_c;
              if (drop_count != '1) drop_count <= drop_count + STAT_WIDTH'(1);
              state <= SETTLE;
            end else if ((due0_c || due1_c) && !gen_busy) begin
              gen_trigger <= 1'b1;
              gen_sel     <= win_c;
              ch0_rden    <= !win_c;
              ch1_rden    <= win_c;
              if (both_due_c && (collision_count != '1)) begin
                collision_count <= collision_count + STAT_WIDTH'(1);
              end
              if (tie_c) rr_ptr <= !win_c;
              state <= SETTLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_line_scheduler.sv
// Bench for delay_line_scheduler: FIFOs and a rule-level reference model live
// in the bench; directed scenarios plus randomized traffic.
module tb_delay_line_scheduler;

  localparam int CW   = 17;
  localparam int LW   = 64;
  localparam int SW   = 16;
  localparam int M    = 1 << CW;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset, enable, gen_busy;
  logic [CW-1:0] ctr_s, ch0_data, ch1_data;
  logic          ch0_empty, ch1_empty;
  logic          ch0_rden, ch1_rden, gen_trigger, gen_sel;
  logic [SW-1:0] drop_count, collision_count;

  delay_line_scheduler #(.CTR_WIDTH(CW), .LATE_WINDOW(LW), .STAT_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ctr(ctr_s),
    .ch0_empty(ch0_empty), .ch0_data(ch0_data),
    .ch1_empty(ch1_empty), .ch1_data(ch1_data),
    .ch0_rden(ch0_rden), .ch1_rden(ch1_rden),
    .gen_busy(gen_busy), .gen_trigger(gen_trigger), .gen_sel(gen_sel),
    .drop_count(drop_count), .collision_count(collision_count)
  );

  always #5 clk = ~clk;

  int q0[$];
  int q1[$];
  int ctr;
  int checks = 0;
  int failures = 0;
  int trig_ctrs[$];
  int trig_sels[$];
  int pops;

  // Model state: outputs expected during the current cycle
  bit m_rden0, m_rden1, m_trig, m_sel, m_rr;
  int m_drop, m_coll;
  bit n_rden0, n_rden1, n_trig, n_sel, n_rr;
  int n_drop, n_coll;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got=%0d expected=%0d", name, $time, got, exp);
    end
  endtask

  function automatic int age_of(input int head, input int c);
    return ((c - head) % M + M) % M;
  endfunction

  // 0 = empty or future, 1 = due, 2 = stale
  function automatic int cls(input int head, input int c);
    int a;
    a = age_of(head, c);
    if (a >= M / 2) return 0;
    if (a < LW) return 1;
    return 2;
  endfunction

  task automatic refresh();
    ctr_s     = CW'(ctr);
    ch0_empty = (q0.size() == 0);
    ch1_empty = (q1.size() == 0);
    ch0_data  = (q0.size() != 0) ? CW'(q0[0]) : '0;
    ch1_data  = (q1.size() != 0) ? CW'(q1[0]) : '0;
  endtask

  // A decision is only taken in a cycle with no strobe in flight.
  task automatic model_eval();
    int c0, c1, a0, a1;
    bit w;
    n_rden0 = 0; n_rden1 = 0; n_trig = 0;
    n_sel = m_sel; n_rr = m_rr; n_drop = m_drop; n_coll = m_coll;
    if (reset) begin
      n_sel = 0; n_rr = 0; n_drop = 0; n_coll = 0;
      return;
    end
    if (m_rden0 || m_rden1 || !enable) return;
    c0 = (q0.size() != 0) ? cls(q0[0], ctr) : 0;
    c1 = (q1.size() != 0) ? cls(q1[0], ctr) : 0;
    a0 = (q0.size() != 0) ? age_of(q0[0], ctr) : 0;
    a1 = (q1.size() != 0) ? age_of(q1[0], ctr) : 0;
    if (c0 == 2 || c1 == 2) begin
      if (c0 == 2) n_rden0 = 1; else n_rden1 = 1;
      if (n_drop < SMAX) n_drop++;
    end else if ((c0 == 1 || c1 == 1) && !gen_busy) begin
      if (c0 == 1 && c1 == 1) begin
        if (n_coll < SMAX) n_coll++;
        if (a0 > a1) w = 0;
        else if (a1 > a0) w = 1;
        else begin
          w = m_rr;
          n_rr = !w;
        end
      end else begin
        w = (c1 == 1);
      end
      n_trig = 1; n_sel = w;
      if (w) n_rden1 = 1; else n_rden0 = 1;
    end
  endtask

  task automatic step();
    refresh();
    model_eval();
    @(posedge clk);
    #1;
    if (m_rden0 && q0.size() != 0) void'(q0.pop_front());
    if (m_rden1 && q1.size() != 0) void'(q1.pop_front());
    m_rden0 = n_rden0; m_rden1 = n_rden1; m_trig = n_trig; m_sel = n_sel;
    m_rr = n_rr; m_drop = n_drop; m_coll = n_coll;
    ctr = (ctr + 1) % M;
    if (m_trig) begin
      trig_ctrs.push_back(ctr);
      trig_sels.push_back(int'(m_sel));
    end
    if (m_rden0 || m_rden1) pops++;
    refresh();
    @(negedge clk);
    chk("ch0_rden", int'(ch0_rden), int'(m_rden0));
    chk("ch1_rden", int'(ch1_rden), int'(m_rden1));
    chk("gen_trigger", int'(gen_trigger), int'(m_trig));
    chk("gen_sel", int'(gen_sel), int'(m_sel));
    chk("drop_count", int'(drop_count), m_drop);
    chk("collision_count", int'(collision_count), m_coll);
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
    q0.delete(); q1.delete();
    trig_ctrs.delete(); trig_sels.delete();
    pops = 0;
  endtask

  task automatic clear_log();
    trig_ctrs.delete(); trig_sels.delete();
    pops = 0;
  endtask

  initial begin
    int guard;
    reset = 1; enable = 1; gen_busy = 0; ctr = 0; pops = 0;
    refresh();
    do_reset();

    // Single due entry
    ctr = 90; q0.push_back(100);
    repeat (21) step();
    chk("t1_trig_num", trig_ctrs.size(), 1);
    if (trig_ctrs.size() == 1) begin
      chk("t1_trig_ctr", trig_ctrs[0], 101);
      chk("t1_sel", trig_sels[0], 0);
    end
    chk("t1_drop", m_drop, 0);

    // Equal-age tie, then a repeat tie favouring ch1
    do_reset();
    ctr = 495; q0.push_back(500); q1.push_back(500);
    repeat (12) step();
    ctr = 595; q0.push_back(600); q1.push_back(600);
    repeat (12) step();
    chk("t2_trig_num", trig_ctrs.size(), 4);
    if (trig_ctrs.size() == 4) begin
      chk("t2_ctr0", trig_ctrs[0], 501); chk("t2_sel0", trig_sels[0], 0);
      chk("t2_ctr1", trig_ctrs[1], 503); chk("t2_sel1", trig_sels[1], 1);
      chk("t2_ctr2", trig_ctrs[2], 601); chk("t2_sel2", trig_sels[2], 1);
      chk("t2_ctr3", trig_ctrs[3], 603); chk("t2_sel3", trig_sels[3], 0);
    end
    chk("t2_coll", m_coll, 2);

    // Busy deferral
    do_reset();
    ctr = 190; q1.push_back(200); gen_busy = 1;
    guard = 0;
    while (ctr <= 230 && guard < 100) begin step(); guard++; end
    gen_busy = 0;
    repeat (6) step();
    chk("t3_trig_num", trig_ctrs.size(), 1);
    if (trig_ctrs.size() == 1) begin
      chk("t3_trig_ctr", trig_ctrs[0], 232);
      chk("t3_sel", trig_sels[0], 1);
    end
    chk("t3_drop", m_drop, 0);

    // Stale drop
    do_reset();
    ctr = 1100; q0.push_back(1000);
    repeat (4) step();
    chk("t4_drop", m_drop, 1);
    chk("t4_trig_num", trig_ctrs.size(), 0);
    chk("t4_pops", pops, 1);

    // Counter wrap, then a future head that must be held
    do_reset();
    ctr = 131065; q0.push_back(131071);
    repeat (11) step();
    chk("t5_trig_num", trig_ctrs.size(), 1);
    if (trig_ctrs.size() == 1) chk("t5_trig_ctr", trig_ctrs[0], 0);
    do_reset();
    ctr = 131000; q0.push_back(10);
    repeat (5) step();
    chk("t5_future_trig", trig_ctrs.size(), 0);
    chk("t5_future_held", q0.size(), 1);

    // Reset during SETTLE, then enable gating
    do_reset();
    ctr = 2000; q0.push_back(2000); q1.push_back(2000);
    step();
    chk("t6_coll_pre", m_coll, 1);
    reset = 1;
    step();
    reset = 0;
    chk("t6_coll_post", m_coll, 0);
    q0.delete(); q1.delete(); clear_log();
    enable = 0; ctr = 3000; q0.push_back(3000);
    repeat (3) step();
    chk("t6_gated", trig_ctrs.size(), 0);
    enable = 1;
    repeat (3) step();
    chk("t6_trig_num", trig_ctrs.size(), 1);
    if (trig_ctrs.size() == 1) chk("t6_trig_ctr", trig_ctrs[0], 3004);

    // Randomized traffic across a counter rollover
    do_reset();
    ctr = M - 1500;
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      gen_busy = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      if (q0.size() < 6 && $urandom_range(0, 3) == 0)
        q0.push_back((ctr + M + int'($urandom_range(0, 260)) - 150) % M);
      if (q1.size() < 6 && $urandom_range(0, 3) == 0)
        q1.push_back((ctr + M + int'($urandom_range(0, 260)) - 150) % M);
      step();
    end
    reset = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_line_scheduler.md
# delay_line_scheduler

Schedules emission of delayed pulses from two timestamp FIFOs onto a single shared pulse generator. Each FIFO holds release timestamps (counter value at which a pulse is due). The block compares FIFO heads with the free-running delay counter using wrap-safe arithmetic, arbitrates when both are due, discards stale entries, and issues single-cycle triggers to the generator. It replaces the single-FIFO comparator when the delay line runs two channels.

## Interface
- CTR_WIDTH, 17: width of the timestamp counter and FIFO data.
- LATE_WINDOW, 64: a head this many cycles or more past due is stale; must be ≥2 and <2^(CTR_WIDTH-1).
- STAT_WIDTH, 16: width of the saturating statistics counters.

- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high; clears all state.
- enable  in  1  0 = no pops, no triggers; counters hold.
- ctr  in  CTR_WIDTH  free-running timestamp counter; wraps modulo 2^CTR_WIDTH.
- ch0_empty / ch1_empty  in  1  FIFO empty flag.
- ch0_data / ch1_data  in  CTR_WIDTH  FIFO head; valid while the matching empty is 0.
- ch0_rden / ch1_rden  out  1  registered one-cycle pop.
- gen_busy  in  1  pulse generator is emitting; a trigger is not accepted.
- gen_trigger  out  1  registered one-cycle fire strobe.
- gen_sel  out  1  channel of the current or last trigger; held between triggers.
- drop_count  out  STAT_WIDTH  stale entries discarded; saturates at all-ones.
- collision_count  out  STAT_WIDTH  cycles where both heads were due and one was deferred; saturates.

## Operation
- age_n = (ctr − chn_data) mod 2^CTR_WIDTH, computed at CTR_WIDTH bits.
- Classification when non-empty:
  - future: age ≥ 2^(CTR_WIDTH-1).
  - due: age < LATE_WINDOW.
  - stale: otherwise.
- States:
  - IDLE: evaluates heads every cycle.
  - SETTLE: one cycle; no evaluation and no new outputs.
- IDLE decisions, in priority order, only when enable=1:
  1. Any head is stale: pop it and increment drop_count. If both are stale, pop ch0. Go to SETTLE.
  2. One or more heads are due and gen_busy=0: pick a winner. Assert gen_trigger and the winner's rden, set gen_sel to the winner, and go to SETTLE.
     - If only one head is due, it wins.
     - If both are due, the larger age wins.
     - On equal age, round-robin decides: the channel not granted last wins. The pointer updates only on tie grants and resets to favour ch0.
     - If both are due, increment collision_count.
  3. A head is due but gen_busy=1: defer, stay in IDLE, no pop. The head may later turn stale and is then dropped under rule 1.
  4. Otherwise stay in IDLE.
- SETTLE always returns to IDLE after one cycle. This guarantees the popped FIFO presents its new head before the next evaluation.
- enable=0 in IDLE: no action, all outputs other than counters low. Deasserting enable while in SETTLE still completes the in-flight pop.
- Reset values:
  - ch0_rden, ch1_rden, gen_trigger, gen_sel: 0.
  - drop_count, collision_count: 0.
  - State: IDLE. RR pointer: favour ch0.
- Reset asserted mid-SETTLE aborts without further pops. Outputs are 0 on the cycle after reset is sampled.

## Timing
- Decision on the edge where IDLE samples the condition; the rden/gen_trigger strobe is high for exactly the following cycle.
- Latency: a head equal to ctr at cycle t gives gen_trigger at cycle t+1, when ctr = head+1. The upstream DELAY offset accounts for this one cycle.
- Maximum event rate: one pop per 2 cycles across both channels.
- gen_busy is sampled only in IDLE. The generator must raise busy no later than the cycle after gen_trigger; SETTLE covers that gap.
- Counter increments occur on the same edge as the corresponding strobe.
- Wrap-around: classification is exact across counter rollover, e.g. head=2^CTR_WIDTH−1 and ctr=0 gives age=1, which is due.

## Test plan
- Single due entry: ch0 head=100, ctr sweeps 90→110, gen_busy=0 → gen_trigger and ch0_rden high only in the cycle with ctr=101; gen_sel=0; drop_count=0.
- Simultaneous due, equal age: both heads=500 → ch0 fires at ctr=501. SETTLE follows, then ch1 fires at ctr=503 (age 2). collision_count=1. A repeat tie then fires ch1 first.
- Busy deferral: ch1 head=200, gen_busy=1 over ctr 195–230, then 0 → trigger with gen_sel=1 in the cycle after busy drops (ctr=232); no drop.
- Stale drop: ch0 head=1000 appears when ctr=1100 with LATE_WINDOW=64 → ch0_rden pulse with no gen_trigger; drop_count=1.
- Wrap: CTR_WIDTH=17, head=131071, ctr rolls 131065→3 → trigger at ctr=0. A head of 10 while ctr=131000 is classified future and held.
- Reset/enable: reset asserted in the SETTLE cycle → next cycle all outputs and counters 0. With enable=0 and a due head, no strobe occurs; it fires one cycle after enable=1 if still due.
